// File: rtl/mips_multicycle_ctrl_if.sv
// Purpose : control bundle between the multi-cycle MIPS main FSM and its datapath.
// Latency : none, wires only; controller strobes are a Moore decode of the FSM state.
// Backpressure: mem_ready from the memory side stalls FETCH/MEMRD/MEMWR until the access completes.
// Ports   : master = controller (drives strobes, state_o, trap, instr_count),
//           slave  = datapath/memory (drives opcode, mem_ready, alu_zero).
interface mips_multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        alu_zero;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemtoReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  PCSource;
    logic [3:0]  state_o;
    logic        trap;
    logic [31:0] instr_count;

    modport master (
        input  opcode, mem_ready, alu_zero,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state_o, trap, instr_count
    );

    modport slave (
        output opcode, mem_ready, alu_zero,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, state_o, trap, instr_count
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Purpose : main control FSM of the multi-cycle MIPS core (fetch/decode/exec/mem/writeback, trap on bad opcode).
// Latency : CPI LW 5, R/ADDI/SUBI/SW 4, BEQ/J 3; outputs are a combinational decode of the current state.
// Backpressure: mem_ready=0 holds FETCH, MEMRD and MEMWR with their memory strobes stable, one extra cycle each.
// Ports   : clk, rst (async, active-high); bus = master side of mips_multicycle_ctrl_if.
module mips_multicycle_ctrl (
    input  logic               clk,
    input  logic               rst,
    mips_multicycle_ctrl_if.master bus
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SUBI  = 6'h0E;
    localparam logic [5:0] OP_J     = 6'h02;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_EXEC_I = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t      state;
    logic [31:0] instr_count;
    logic        retire;

    // Cycles in which an instruction completes; a store completes only
    // once memory accepts the write.
    always_comb begin
        retire = 1'b0;
        case (state)
            S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: retire = 1'b1;
            S_MEMWR:                                   retire = bus.mem_ready;
            default:                                   retire = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_FETCH;
            instr_count <= 32'd0;
        end else begin
            if (retire)
                instr_count <= instr_count + 32'd1;
            case (state)
                S_FETCH:  if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.opcode)
                        OP_LW, OP_SW:     state <= S_MEMADR;
                        OP_RTYPE:         state <= S_EXEC_R;
                        OP_BEQ:           state <= S_BRANCH;
                        OP_ADDI, OP_SUBI: state <= S_EXEC_I;
                        OP_J:             state <= S_JUMP;
                        default:          state <= S_TRAP;
                    endcase
                end
                // opcode is re-sampled here; anything that is no longer a
                // memory op is treated as illegal rather than guessed at.
                S_MEMADR: begin
                    if (bus.opcode == OP_LW)
                        state <= S_MEMRD;
                    else if (bus.opcode == OP_SW)
                        state <= S_MEMWR;
                    else
                        state <= S_TRAP;
                end
                S_MEMRD:  if (bus.mem_ready) state <= S_MEMWB;
                S_MEMWR:  if (bus.mem_ready) state <= S_FETCH;
                S_EXEC_R: state <= S_ALUWB;
                S_EXEC_I: state <= S_IWB;
                S_MEMWB, S_ALUWB, S_IWB, S_BRANCH, S_JUMP: state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_FETCH;   // unused encodings 13-15
            endcase
        end
    end

    // Moore decode; rst blanks everything so nothing strobes while the
    // core is held in reset.
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;
        bus.trap        = 1'b0;
        bus.state_o     = 4'd0;
        bus.instr_count = 32'd0;
        if (!rst) begin
            bus.state_o     = state;
            bus.instr_count = instr_count;
            case (state)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUSrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                S_DECODE: bus.ALUSrcB = 2'b11;
                S_MEMADR: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                end
                S_MEMRD: begin
                    bus.IorD    = 1'b1;
                    bus.MemRead = 1'b1;
                end
                S_MEMWB: begin
                    bus.MemtoReg = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_MEMWR: begin
                    bus.IorD     = 1'b1;
                    bus.MemWrite = 1'b1;
                end
                S_EXEC_R: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUOp   = 2'b10;
                end
                S_ALUWB: begin
                    bus.RegDst   = 1'b1;
                    bus.RegWrite = 1'b1;
                end
                S_EXEC_I: begin
                    bus.ALUSrcA = 1'b1;
                    bus.ALUSrcB = 2'b10;
                    bus.ALUOp   = (bus.opcode == OP_SUBI) ? 2'b01 : 2'b00;
                end
                S_IWB: bus.RegWrite = 1'b1;
                S_BRANCH: begin
                    bus.ALUSrcA     = 1'b1;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSource    = 2'b01;
                end
                S_JUMP: begin
                    bus.PCWrite  = 1'b1;
                    bus.PCSource = 2'b10;
                end
                S_TRAP:  bus.trap = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Purpose : directed self-checking bench for mips_multicycle_ctrl.
// Latency : checks state_o and all strobes every cycle, 1-2 ns after the rising edge.
// Backpressure: mem_ready is driven low in FETCH, MEMRD and MEMWR to exercise wait states.
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
    //  RegWrite,ALUSrcA,ALUSrcB[1:0],ALUOp[1:0],PCSource[1:0],trap}
    logic [16:0] ctl;
    assign ctl = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite,
                  bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.trap};

    localparam logic [16:0] C_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FWAIT  = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_EXECR  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_ADDI   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_SUBI   = 17'b0_0_0_0_0_0_0_0_0_1_10_01_00_0;
    localparam logic [16:0] C_IWB    = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_TRAP   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check the current cycle (inputs already applied), then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [16:0] c);
        #1;
        chk({tag, "_state"}, {28'd0, bus.state_o}, {28'd0, st});
        chk({tag, "_ctl"}, {15'd0, ctl}, {15'd0, c});
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.opcode    = 6'h00;
        bus.mem_ready = 1'b1;
        bus.alu_zero  = 1'b0;

        // Reset held: everything blanked even though FETCH would strobe.
        #3;
        chk("rst_ctl", {15'd0, ctl}, {15'd0, C_ZERO});
        chk("rst_state", {28'd0, bus.state_o}, 32'd0);
        chk("rst_count", bus.instr_count, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // OR: 0,1,6,7,0; opcode garbage after DECODE must be ignored.
        bus.opcode = 6'h00;
        cyc("or_f", 4'd0, C_FETCH);
        cyc("or_d", 4'd1, C_DECODE);
        bus.opcode = 6'h3F;
        cyc("or_x", 4'd6, C_EXECR);
        cyc("or_wb", 4'd7, C_ALUWB);
        chk("or_count", bus.instr_count, 32'd1);

        // SUBI: 0,1,9,10,0 with ALUOp=01 in EXEC_I.
        bus.opcode = 6'h0E;
        cyc("subi_f", 4'd0, C_FETCH);
        cyc("subi_d", 4'd1, C_DECODE);
        cyc("subi_x", 4'd9, C_SUBI);
        cyc("subi_wb", 4'd10, C_IWB);
        chk("subi_count", bus.instr_count, 32'd2);

        // ADDI with one fetch wait state.
        bus.opcode = 6'h08;
        bus.mem_ready = 1'b0;
        cyc("addi_fw", 4'd0, C_FWAIT);
        bus.mem_ready = 1'b1;
        cyc("addi_f", 4'd0, C_FETCH);
        cyc("addi_d", 4'd1, C_DECODE);
        cyc("addi_x", 4'd9, C_ADDI);
        cyc("addi_wb", 4'd10, C_IWB);
        chk("addi_count", bus.instr_count, 32'd3);

        // J: 3 cycles.
        bus.opcode = 6'h02;
        cyc("j_f", 4'd0, C_FETCH);
        cyc("j_d", 4'd1, C_DECODE);
        cyc("j_j", 4'd11, C_JUMP);
        chk("j_count", bus.instr_count, 32'd4);

        // SW with two MEMWR wait cycles: 6 cycles, single retire.
        bus.opcode = 6'h2B;
        cyc("sw_f", 4'd0, C_FETCH);
        cyc("sw_d", 4'd1, C_DECODE);
        cyc("sw_a", 4'd2, C_MEMADR);
        bus.mem_ready = 1'b0;
        cyc("sw_w0", 4'd5, C_MEMWR);
        cyc("sw_w1", 4'd5, C_MEMWR);
        chk("sw_count_wait", bus.instr_count, 32'd4);
        bus.mem_ready = 1'b1;
        cyc("sw_w2", 4'd5, C_MEMWR);
        chk("sw_count", bus.instr_count, 32'd5);

        // LW with one MEMRD wait: 6 cycles.
        bus.opcode = 6'h23;
        cyc("lw_f", 4'd0, C_FETCH);
        cyc("lw_d", 4'd1, C_DECODE);
        cyc("lw_a", 4'd2, C_MEMADR);
        bus.mem_ready = 1'b0;
        cyc("lw_rw", 4'd3, C_MEMRD);
        bus.mem_ready = 1'b1;
        cyc("lw_r", 4'd3, C_MEMRD);
        cyc("lw_wb", 4'd4, C_MEMWB);
        chk("lw_count", bus.instr_count, 32'd6);

        // BEQ with alu_zero=1.
        bus.opcode   = 6'h04;
        bus.alu_zero = 1'b1;
        cyc("beq_f", 4'd0, C_FETCH);
        cyc("beq_d", 4'd1, C_DECODE);
        cyc("beq_b", 4'd8, C_BRANCH);
        chk("beq_state_after", {28'd0, bus.state_o}, 32'd0);
        chk("beq_count", bus.instr_count, 32'd7);
        bus.alu_zero = 1'b0;

        // rst pulse in MEMRD of an LW: immediate blanking, no RegWrite, restart.
        bus.opcode = 6'h23;
        cyc("lwr_f", 4'd0, C_FETCH);
        cyc("lwr_d", 4'd1, C_DECODE);
        cyc("lwr_a", 4'd2, C_MEMADR);
        bus.mem_ready = 1'b0;
        #1;
        chk("lwr_memrd", {28'd0, bus.state_o}, 32'd3);
        rst = 1'b1;
        #1;
        chk("lwr_rst_ctl", {15'd0, ctl}, {15'd0, C_ZERO});
        chk("lwr_rst_count", bus.instr_count, 32'd0);
        bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("lwr_rst_regwrite", {31'd0, bus.RegWrite}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("lwr_count_after", bus.instr_count, 32'd0);
        cyc("lwr_refetch", 4'd0, C_FETCH);

        // Illegal opcode: TRAP for 10 cycles regardless of inputs, then rst.
        bus.opcode = 6'h3F;
        cyc("trap_d", 4'd1, C_DECODE);
        for (int i = 0; i < 10; i++) begin
            bus.opcode    = 6'(i);
            bus.mem_ready = i[0];
            cyc("trap_hold", 4'd12, C_TRAP);
        end
        rst = 1'b1;
        #1;
        chk("trap_rst_state", {28'd0, bus.state_o}, 32'd0);
        chk("trap_rst_trap", {31'd0, bus.trap}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        cyc("trap_refetch", 4'd0, C_FETCH);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
